divider_seq: RTL

Sequential unsigned restoring divider for the ALU datapath, the inverse of the multiply path. It accepts a dividend/divisor pair on a start pulse and produces quotient and remainder after w iterations, one quotient bit per clock. Each trial subtraction is done by one `adder_rca` instance of width w+1 with `carry_in` tied to 1 (subtract mode).

---
 rtl/divider_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/divider_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// trial subtraction through a single (w+1)-bit ripple-carry adder.

module adder_rca #(
    parameter int w = 9
) (
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    input  logic         carry_in,
    output logic [w-1:0] sum,
    output logic         carry_out
);

    logic carry;

    always_comb begin
        carry = carry_in;
        sum   = '0;
        for (int i = 0; i < w; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        carry_out = carry;
    end

endmodule

module divider_seq #(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [w-1:0] dividend,
    input  logic [w-1:0] divisor,
    output logic [w-1:0] quotient,
    output logic [w-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = $clog2(w + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [w:0]    a_reg;
    logic [w-1:0]  q_reg;
    logic [w-1:0]  m_reg;
    logic [CW-1:0] cnt;

    logic [w:0]    a_shift;
    logic [w-1:0]  q_shift;
    logic [w:0]    m_inv;
    logic [w:0]    trial;
    logic          no_borrow;
    logic [w:0]    a_new;
    logic [w-1:0]  q_new;

    logic          accept;
    logic          zero_div;
    logic          last_iter;

    // Shift {A,Q} left; A's top bit is always 0 here, so it drops off harmlessly.
    assign a_shift = (a_reg << 1) | {{w{1'b0}}, q_reg[w-1]};
    assign q_shift = q_reg << 1;
    assign m_inv   = ~{1'b0, m_reg};

    adder_rca #(
        .w(w + 1)
    ) u_sub (
        .a        (a_shift),
        .b        (m_inv),
        .carry_in (1'b1),
        .sum      (trial),
        .carry_out(no_borrow)
    );

    assign a_new = no_borrow ? trial : a_shift;
    assign q_new = q_shift | {{(w - 1){1'b0}}, no_borrow};

    assign accept    = start && (state == IDLE || state == DONE);
    assign zero_div  = (divisor == '0);
    assign last_iter = (state == RUN) && (cnt == CW'(1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = zero_div ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            q_reg <= '0;
            m_reg <= '0;
            cnt   <= '0;
        end else if (accept && !zero_div) begin
            a_reg <= '0;
            q_reg <= dividend;
            m_reg <= divisor;
            cnt   <= CW'(w);
        end else if (state == RUN) begin
            a_reg <= a_new;
            q_reg <= q_new;
            cnt   <= cnt - CW'(1);
        end
    end

    // Results move only on a final iteration or a divide-by-zero start.
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept && zero_div) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if (last_iter) begin
            quotient    <= q_new;
            remainder   <= a_new[w-1:0];
            div_by_zero <= 1'b0;
        end
    end

endmodule
